// File: rtl/image_streamer.sv
// Frame source for the LeNet-5 front end: reads one image from the pixel ROM and emits a gap-free raster stream.
// Optional zero border is compiled in with `define IMAGE_STREAMER_PAD_EN.
module image_streamer #(
  parameter int COLS    = 32,
  parameter int ROWS    = 32,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 10,
  parameter int ROM_LAT = 1,
  parameter int PAD     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              sof,
  output logic              sol,
  output logic              eol,
  output logic              eof,
  output logic              busy,
  output logic              done
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  if (ROM_LAT < 1 || ROM_LAT > 4 || PAD < 0) begin : g_bad_cfg
    $error("image_streamer: ROM_LAT must be 1..4 and PAD non-negative");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  typedef struct packed {
    logic vld;
    logic sof;
    logic sol;
    logic eol;
    logic eof;
    logic pad;
  } side_t;

  state_t            state, state_nxt;
  logic [RW-1:0]     row, row_nxt;
  logic [CW-1:0]     col, col_nxt;
  logic              issue, last, done_nxt;
  side_t             slot_s;
  logic [ADDR_W-1:0] addr_s;
  // Stage 0 is the issue register; stage ROM_LAT lines up with rom_data.
  side_t [ROM_LAT:0] vld_pipe;

  assign last = (row == RW'(ROWS-1)) && (col == CW'(COLS-1));

  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    col_nxt   = col;
    issue     = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE:  if (start) begin
               issue     = 1'b1;
               state_nxt = ISSUE;
             end
      ISSUE: issue = 1'b1;
      // The registered eof marks the last pixel leaving, so the ROM pipe is empty here.
      DRAIN: if (eof) begin
               done_nxt  = 1'b1;
               state_nxt = IDLE;
             end
      default: state_nxt = IDLE;
    endcase
    if (issue) begin
      if (col == CW'(COLS-1)) begin
        col_nxt = '0;
        row_nxt = last ? '0 : row + 1'b1;
      end else begin
        col_nxt = col + 1'b1;
      end
      if (last) state_nxt = DRAIN;
    end
  end

  always_comb begin
    slot_s     = '0;
    slot_s.vld = 1'b1;
    slot_s.sof = (row == '0) && (col == '0);
    slot_s.sol = (col == '0);
    slot_s.eol = (col == CW'(COLS-1));
    slot_s.eof = last;
`ifdef IMAGE_STREAMER_PAD_EN
    slot_s.pad = (int'(row) < PAD) || (int'(row) >= ROWS-PAD) ||
                 (int'(col) < PAD) || (int'(col) >= COLS-PAD);
    addr_s     = ADDR_W'((int'(row) - PAD) * (COLS - 2*PAD) + (int'(col) - PAD));
`else
    addr_s     = ADDR_W'(int'(row) * COLS + int'(col));
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      rom_en    <= 1'b0;
      rom_addr  <= '0;
      vld_pipe  <= '0;
      pix_data  <= '0;
      pix_valid <= 1'b0;
      sof       <= 1'b0;
      sol       <= 1'b0;
      eol       <= 1'b0;
      eof       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      row   <= row_nxt;
      col   <= col_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= done_nxt;
      // Border slots skip the ROM; rom_addr keeps its last value.
      rom_en <= issue && !slot_s.pad;
      if (issue && !slot_s.pad) rom_addr <= addr_s;
      vld_pipe[0] <= issue ? slot_s : '0;
      for (int k = 1; k <= ROM_LAT; k++) vld_pipe[k] <= vld_pipe[k-1];
      pix_valid <= vld_pipe[ROM_LAT].vld;
      sof       <= vld_pipe[ROM_LAT].sof;
      sol       <= vld_pipe[ROM_LAT].sol;
      eol       <= vld_pipe[ROM_LAT].eol;
      eof       <= vld_pipe[ROM_LAT].eof;
      pix_data  <= (vld_pipe[ROM_LAT].vld && !vld_pipe[ROM_LAT].pad) ? rom_data : '0;
    end
  end

endmodule

// File: tb/tb_image_streamer.sv
// Directed bench for image_streamer: ROM_LAT=1 and ROM_LAT=3 instances sharing clock and reset.
module tb_image_streamer;

  localparam int COLS = 32;
  localparam int ROWS = 32;
  localparam int N    = COLS * ROWS;
  localparam int T0   = 5;
`ifdef IMAGE_STREAMER_PAD_EN
  localparam int N_EN = 784;
`else
  localparam int N_EN = 1024;
`endif

  logic clk, rst_n, st, sel_b;
  int   cyc;
  int   errors = 0;
  int   checks = 0;

  logic       rom_en_a, pv_a, sof_a, sol_a, eol_a, eof_a, busy_a, done_a;
  logic [9:0] rom_addr_a;
  logic [7:0] rom_data_a, pix_data_a, q_a;
  logic       rom_en_b, pv_b, sof_b, sol_b, eol_b, eof_b, busy_b, done_b;
  logic [9:0] rom_addr_b;
  logic [7:0] rom_data_b, pix_data_b;
  logic [7:0] q_b [0:2];
  logic [7:0] mem [0:1023];

  image_streamer #(.ROM_LAT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(st && !sel_b),
    .rom_en(rom_en_a), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
    .pix_data(pix_data_a), .pix_valid(pv_a), .sof(sof_a), .sol(sol_a),
    .eol(eol_a), .eof(eof_a), .busy(busy_a), .done(done_a));

  image_streamer #(.ROM_LAT(3)) u_b (
    .clk(clk), .rst_n(rst_n), .start(st && sel_b),
    .rom_en(rom_en_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
    .pix_data(pix_data_b), .pix_valid(pv_b), .sof(sof_b), .sol(sol_b),
    .eol(eol_b), .eof(eof_b), .busy(busy_b), .done(done_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  // ROM models; a disabled read returns junk so skipped border reads are visible.
  always @(posedge clk) begin
    q_a    <= rom_en_a ? mem[rom_addr_a] : 8'h5A;
    q_b[0] <= rom_en_b ? mem[rom_addr_b] : 8'h5A;
    q_b[1] <= q_b[0];
    q_b[2] <= q_b[1];
  end
  assign rom_data_a = q_a;
  assign rom_data_b = q_b[2];

  logic       o_en, o_v, o_sof, o_sol, o_eol, o_eof, o_busy, o_done;
  logic [9:0] o_addr;
  logic [7:0] o_pix;
  assign o_en   = sel_b ? rom_en_b   : rom_en_a;
  assign o_addr = sel_b ? rom_addr_b : rom_addr_a;
  assign o_pix  = sel_b ? pix_data_b : pix_data_a;
  assign o_v    = sel_b ? pv_b       : pv_a;
  assign o_sof  = sel_b ? sof_b      : sof_a;
  assign o_sol  = sel_b ? sol_b      : sol_a;
  assign o_eol  = sel_b ? eol_b      : eol_a;
  assign o_eof  = sel_b ? eof_b      : eof_a;
  assign o_busy = sel_b ? busy_b     : busy_a;
  assign o_done = sel_b ? done_b     : done_a;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic slot_in(input int r, input int c);
`ifdef IMAGE_STREAMER_PAD_EN
    return (r >= 2) && (r < 30) && (c >= 2) && (c < 30);
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [9:0] slot_addr(input int r, input int c);
`ifdef IMAGE_STREAMER_PAD_EN
    return 10'((r - 2) * 28 + (c - 2));
`else
    return 10'(r * COLS + c);
`endif
  endfunction

  function automatic logic [7:0] exp_pix(input int r, input int c);
`ifdef IMAGE_STREAMER_PAD_EN
    return slot_in(r, c) ? 8'hFF : 8'h00;
`else
    return 8'((r * COLS + c) & 255);
`endif
  endfunction

  // Start sampled at edge T0; extra start pulses land at edges 100 and 1031 and must be ignored.
  task automatic run_frame(input int lat, input int last);
    int         k, idx, s, n_en, n_sol, n_eol;
    logic       exp_v, exp_en;
    logic [9:0] exp_addr;
    logic [7:0] ep;
    logic [3:0] ef;
    exp_addr = '0;
    n_en = 0; n_sol = 0; n_eol = 0;
    while (cyc < last) begin
      @(posedge clk);
      #1;
      k  = cyc;
      st = (k == T0-1) || (k == 99) || (k == 1030);
      if (k >= T0) begin
        idx   = k - (T0 + 1 + lat);
        exp_v = (idx >= 0) && (idx < N);
        ep    = exp_v ? exp_pix(idx / COLS, idx % COLS) : 8'h00;
        ef    = exp_v ? {idx == 0, idx % COLS == 0, idx % COLS == COLS-1, idx == N-1} : 4'b0;
        s      = k - T0;
        exp_en = (s >= 0) && (s < N) && slot_in(s / COLS, s % COLS);
        if (exp_en) exp_addr = slot_addr(s / COLS, s % COLS);
        check($sformatf("rom_en@%0d", k),    o_en,   exp_en);
        check($sformatf("rom_addr@%0d", k),  o_addr, exp_addr);
        check($sformatf("pix_valid@%0d", k), o_v,    exp_v);
        check($sformatf("pix_data@%0d", k),  o_pix,  ep);
        check($sformatf("flags@%0d", k),     {o_sof, o_sol, o_eol, o_eof}, ef);
        check($sformatf("busy@%0d", k),      o_busy, (k >= T0) && (k <= T0 + lat + N));
        check($sformatf("done@%0d", k),      o_done, k == T0 + lat + N + 1);
        n_en  += int'(o_en);
        n_sol += int'(o_sol);
        n_eol += int'(o_eol);
      end
    end
    st = 1'b0;
    if (last > T0 + lat + N + 1) begin
      check("rom_en_count", n_en,  N_EN);
      check("sol_count",    n_sol, ROWS);
      check("eol_count",    n_eol, ROWS);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
`ifdef IMAGE_STREAMER_PAD_EN
      mem[i] = 8'hFF;
`else
      mem[i] = 8'(i);
`endif
    end
    rst_n = 1'b0;
    st    = 1'b0;
    sel_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_a", {rom_en_a, rom_addr_a, pix_data_a, pv_a, sof_a, sol_a, eol_a, eof_a, busy_a, done_a}, 32'h0);
    check("reset_b", {rom_en_b, rom_addr_b, pix_data_b, pv_b, sof_b, sol_b, eol_b, eof_b, busy_b, done_b}, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // Full frame at ROM_LAT=1, including ignored start pulses and idle tail.
    run_frame(1, 1040);

    // Mid-frame abort: outputs drop without waiting for a clock edge.
    pulse_reset();
    run_frame(1, 400);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {rom_en_a, rom_addr_a, pix_data_a, pv_a, sof_a, sol_a, eol_a, eof_a, busy_a, done_a}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    run_frame(1, 60);

    // ROM_LAT=3 instance, full frame.
    sel_b = 1'b1;
    pulse_reset();
    run_frame(3, 1045);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
